// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction-fetch stage.
//   - state_t  : fetch FSM encoding (IDLE, FETCH, HALT)
//   - HALT_OP  : opcode treated as HALT when IFETCH_HALT_EN is defined
//   - AW_DEF / DW_DEF : default address / instruction widths
package ifetch_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic [DW_DEF-1:0] HALT_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage in front of a zero-latency instruction memory.
// Owns the PC, drives the memory address, and registers the returned
// instruction with its PC into an output register handed to decode over a
// valid/ready handshake. Supports start gating, stalls, redirects with flush
// and a counter of instructions accepted downstream.
//
// Optional feature: define IFETCH_HALT_EN to treat the all-ones instruction as
// HALT (fetching stops after it; only start or rst leave HALT).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse, IDLE -> FETCH (and HALT -> FETCH)
//   imem_ad / imem_out  memory address (= pc register) / returned instruction
//   redirect_en/_pc     branch/jump taken and its target
//   out_valid/out_ready output handshake
//   out_instr/out_pc    registered instruction and its PC
//   fetch_cnt           instructions accepted downstream (wraps)
//   busy                state == FETCH
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              AW       = AW_DEF,
  parameter int              DW       = DW_DEF,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    imem_ad,
  input  logic [DW-1:0]    imem_out,
  input  logic             redirect_en,
  input  logic [AW-1:0]    redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_instr,
  output logic [AW-1:0]    out_pc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             busy
);

  state_t        state;
  logic [AW-1:0] pc;
  logic          advance;
  logic          handshake;

  // The output register may be refilled when it is empty or being drained.
  assign advance   = !out_valid || out_ready;
  assign handshake = out_valid && out_ready;

  assign imem_ad = pc;
  assign busy    = (state == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fetch_cnt <= '0;
    end else begin
      // A handshake completes in any state, including the redirect cycle.
      if (handshake) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // Redirect in IDLE pre-sets the entry point without starting.
          if (redirect_en) begin
            pc <= redirect_pc;
          end
          if (start) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (redirect_en) begin
            // Flush: the instruction in the output register is dropped.
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (advance) begin
            out_instr <= imem_out;
            out_pc    <= pc;
            out_valid <= 1'b1;
`ifdef IFETCH_HALT_EN
            // pc stays on the HALT address so start resumes at pc+1.
            if (imem_out == {DW{1'b1}}) begin
              state <= HALT;
            end else begin
              pc <= pc + AW'(1);
            end
`else
            pc <= pc + AW'(1);
`endif
          end
        end

`ifdef IFETCH_HALT_EN
        HALT: begin
          // The HALT instruction itself still drains to decode.
          if (handshake) begin
            out_valid <= 1'b0;
          end
          if (start) begin
            state <= FETCH;
            pc    <= pc + AW'(1);
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  imem_ad;
  logic [7:0]  imem_out;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_instr;
  logic [7:0]  out_pc;
  logic [15:0] fetch_cnt;
  logic        busy;

  // Combinational zero-latency instruction memory.
  logic [7:0] mem [256];
  assign imem_out = mem[imem_ad];

  ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_ad    (imem_ad),
    .imem_out   (imem_out),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .fetch_cnt  (fetch_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  logic ff_at4   = 1'b0;
  logic [7:0] sb [$];

  typedef struct {
    logic       rdy;
    logic       st;
    logic       ren;
    logic [7:0] rpc;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic [7:0] exp_ad;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [7:0] exp_instr(input logic [7:0] a);
    if (ff_at4 && a == 8'd4) return 8'hFF;
    return a + 8'h10;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard compare on each handshake, then advance one clock.
  task automatic step();
    logic [7:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("hs_pc", 32'(out_pc), 32'(e));
        check("hs_instr", 32'(out_instr), 32'(exp_instr(e)));
      end
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    exp_cnt = 0;
    sb.delete();
  endtask

  task automatic start_fetch();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_valid0", 32'(out_valid), 0);
    step();
    check("first_valid", 32'(out_valid), 1);
    check("first_pc", 32'(out_pc), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);

    vecs[0]  = '{1, 0, 0, 8'h00, 1, 8'h01, 8'h02};
    vecs[1]  = '{1, 0, 0, 8'h00, 1, 8'h02, 8'h03};
    vecs[2]  = '{1, 1, 0, 8'h00, 1, 8'h03, 8'h04};
    vecs[3]  = '{1, 0, 0, 8'h00, 1, 8'h04, 8'h05};
    vecs[4]  = '{1, 0, 0, 8'h00, 1, 8'h05, 8'h06};
    vecs[5]  = '{1, 0, 1, 8'h40, 0, 8'h00, 8'h40};
    vecs[6]  = '{1, 0, 0, 8'h00, 1, 8'h40, 8'h41};
    vecs[7]  = '{1, 0, 0, 8'h00, 1, 8'h41, 8'h42};
    vecs[8]  = '{1, 0, 1, 8'hFE, 0, 8'h00, 8'hFE};
    vecs[9]  = '{1, 0, 0, 8'h00, 1, 8'hFE, 8'hFF};
    vecs[10] = '{1, 0, 0, 8'h00, 1, 8'hFF, 8'h00};
    vecs[11] = '{1, 0, 0, 8'h00, 1, 8'h00, 8'h01};
    vecs[12] = '{1, 0, 0, 8'h00, 1, 8'h01, 8'h02};
    vecs[13] = '{0, 0, 1, 8'h20, 0, 8'h00, 8'h20};
    vecs[14] = '{0, 0, 0, 8'h00, 1, 8'h20, 8'h21};
    vecs[15] = '{0, 0, 0, 8'h00, 1, 8'h20, 8'h21};
    vecs[16] = '{1, 0, 0, 8'h00, 1, 8'h21, 8'h22};

    rst = 1'b1; start = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc", 32'(imem_ad), 0);
    check("rst_out_pc", 32'(out_pc), 0);
    check("rst_instr", 32'(out_instr), 0);
    check("rst_cnt", 32'(fetch_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    step();
    check("idle_valid", 32'(out_valid), 0);

    // Streaming, stall at out_pc=2, resume up to 8 accepted.
    for (int i = 0; i < 8; i++) sb.push_back(8'(i));
    start_fetch();
    n = 0;
    while (!(out_valid && out_pc == 8'd2) && n < 20) begin step(); n++; end
    check("reach_pc2", 32'(out_pc), 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", 32'(out_pc), 2);
      check("stall_instr", 32'(out_instr), 32'(exp_instr(8'd2)));
      check("stall_ad", 32'(imem_ad), 3);
      check("stall_cnt", 32'(fetch_cnt), 2);
      check("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    check("resume_pc", 32'(out_pc), 3);
    n = 0;
    while (exp_cnt < 8 && n < 20) begin step(); n++; end
    check("cnt8", 32'(fetch_cnt), 8);
    check("after8_pc", 32'(out_pc), 8);
    check("sb_empty_a", sb.size(), 0);

    // Table-driven redirect / wrap / flush-under-stall sequence.
    do_reset();
    foreach (vecs[i]) begin end
    sb.push_back(8'h00);
    for (int i = 0; i < 17; i++)
      if (vecs[i].rdy && (i == 0 || vecs[i-1].exp_valid) && i != 13)
        sb.push_back(i == 0 ? 8'h00 : vecs[i-1].exp_pc);
    void'(sb.pop_front());
    start_fetch();
    for (int i = 0; i < 17; i++) begin
      out_ready   = vecs[i].rdy;
      start       = vecs[i].st;
      redirect_en = vecs[i].ren;
      redirect_pc = vecs[i].rpc;
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("v%0d_pc", i), 32'(out_pc), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_ad", i), 32'(imem_ad), 32'(vecs[i].exp_ad));
    end
    start = 1'b0; redirect_en = 1'b0; out_ready = 1'b1;
    check("tbl_cnt", 32'(fetch_cnt), 12);
    check("sb_empty_b", sb.size(), 0);

    // Asynchronous reset mid-fetch with out_valid=1.
    check("pre_async_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #2;
    check("async_valid", 32'(out_valid), 0);
    check("async_cnt", 32'(fetch_cnt), 0);
    check("async_pc", 32'(imem_ad), 0);
    check("async_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 0; sb.delete();
    step();
    check("async_idle", 32'(busy), 0);

    // All-ones instruction at address 4.
    mem[4] = 8'hFF;
    ff_at4 = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(8'(i));
    start_fetch();
    n = 0;
    while (!(out_valid && out_pc == 8'd4) && n < 20) begin step(); n++; end
    check("reach_pc4", 32'(out_instr), 32'hFF);
    step();
`ifdef IFETCH_HALT_EN
    check("halt_valid", 32'(out_valid), 0);
    check("halt_busy", 32'(busy), 0);
    check("halt_cnt", 32'(fetch_cnt), 5);
    redirect_en = 1'b1; redirect_pc = 8'h80;
    step();
    redirect_en = 1'b0;
    check("halt_redir_ad", 32'(imem_ad), 4);
    check("halt_redir_valid", 32'(out_valid), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_ad", 32'(imem_ad), 5);
    check("resume_busy", 32'(busy), 1);
    step();
    check("resume_valid", 32'(out_valid), 1);
    check("resume_pc5", 32'(out_pc), 5);
`else
    check("ff_ord_valid", 32'(out_valid), 1);
    check("ff_ord_pc", 32'(out_pc), 5);
    check("ff_ord_busy", 32'(busy), 1);
`endif
    step();
    check("final_cnt", 32'(fetch_cnt), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
